// File: rtl/axi_ram_slave.sv
// AXI3-subset RAM slave: word-addressed on-chip memory serving one read or write
// burst at a time (INCR, WRAP, FIXED), with alternating read/write priority.
module axi_ram_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_WIDTH-1:0] awid,
    input  logic [31:0]         awaddr,
    input  logic [3:0]          awlen,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [31:0]         wdata,
    input  logic [3:0]          wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_WIDTH-1:0] bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_WIDTH-1:0] arid,
    input  logic [31:0]         araddr,
    input  logic [3:0]          arlen,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_WIDTH-1:0] rid,
    output logic [31:0]         rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready,
    output logic [1:0]          o_dbg_state
);

    // Handshakes: a beat transfers on a rising edge where valid and ready are both
    // high; the master's valids never depend on our readies, and ours are decoded
    // from the FSM state only (plus the address-channel valids for arbitration).

    localparam int WW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RD    = 2'd1,
        S_WR    = 2'd2,
        S_WRESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_prio_rd;
    logic [WW-1:0]       r_addr;
    logic [3:0]          r_len;
    logic [3:0]          r_beat;
    logic [1:0]          r_burst;
    logic                r_err;
    logic [31:0]         r_rdata;
    logic                r_rlast;
    logic [ID_WIDTH-1:0] r_rid;
    logic [ID_WIDTH-1:0] r_bid;
    logic [1:0]          r_bresp;
    logic [31:0]         r_mem [DEPTH];

    logic                w_arready;
    logic                w_awready;
    logic                w_wready;
    logic                w_r_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_beat_last;
    logic                w_err_beat;
    logic [WW-1:0]       w_ar_word;
    logic [WW-1:0]       w_aw_word;
    logic [WW-1:0]       w_next_addr;
    logic                w_unused;

    // WRAP only wraps for power-of-two burst lengths; other lengths step like INCR.
    function automatic logic [WW-1:0] f_step(input logic [WW-1:0] w, input logic [3:0] len,
                                             input logic [1:0] burst);
        logic [WW-1:0] m;
        logic [WW-1:0] inc;
        m   = WW'(len);
        inc = w + WW'(1);
        case (burst)
            2'b00:   f_step = w;
            2'b10:   f_step = (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) ?
                              ((w & ~m) | (inc & m)) : inc;
            default: f_step = inc;
        endcase
    endfunction

    assign w_ar_word   = araddr[ADDR_WIDTH-1:2];
    assign w_aw_word   = awaddr[ADDR_WIDTH-1:2];
    assign w_next_addr = f_step(r_addr, r_len, r_burst);
    assign w_beat_last = (r_beat == r_len);
    assign w_err_beat  = (wlast != w_beat_last);
    assign w_r_hs      = (r_state == S_RD) && rready;
    assign w_w_hs      = (r_state == S_WR) && wvalid;
    assign w_b_hs      = (r_state == S_WRESP) && bready;
    assign w_unused    = &{1'b0, awaddr[31:ADDR_WIDTH], awaddr[1:0],
                           araddr[31:ADDR_WIDTH], araddr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_arready    = 1'b0;
        w_awready    = 1'b0;
        w_wready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    w_arready = arvalid && (!awvalid || r_prio_rd);
                    w_awready = awvalid && !w_arready;
                end
                if (w_arready) begin
                    w_next_state = S_RD;
                end else if (w_awready) begin
                    w_next_state = S_WR;
                end
            end
            S_RD: begin
                if (rready && r_rlast) begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR: begin
                w_wready = 1'b1;
                if (wvalid && w_beat_last) begin
                    w_next_state = S_WRESP;
                end
            end
            S_WRESP: begin
                if (bready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio_rd <= 1'b1;
            r_addr    <= '0;
            r_len     <= 4'd0;
            r_beat    <= 4'd0;
            r_burst   <= 2'b00;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
            r_rlast   <= 1'b0;
            r_rid     <= '0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_arready) begin
                r_rid   <= arid;
                r_addr  <= w_ar_word;
                r_len   <= arlen;
                r_burst <= arburst;
                r_beat  <= 4'd0;
                r_rdata <= r_mem[w_ar_word];
                r_rlast <= (arlen == 4'd0);
            end else if (w_awready) begin
                r_bid   <= awid;
                r_addr  <= w_aw_word;
                r_len   <= awlen;
                r_burst <= awburst;
                r_beat  <= 4'd0;
                r_err   <= 1'b0;
            end else if (w_r_hs) begin
                if (r_rlast) begin
                    r_rlast   <= 1'b0;
                    r_prio_rd <= ~r_prio_rd;
                end else begin
                    // Prefetch the next beat so a new word is offered every cycle.
                    r_addr  <= w_next_addr;
                    r_beat  <= r_beat + 4'd1;
                    r_rdata <= r_mem[w_next_addr];
                    r_rlast <= ((r_beat + 4'd1) == r_len);
                end
            end else if (w_w_hs) begin
                if (w_err_beat) begin
                    r_err <= 1'b1;
                end
                if (w_beat_last) begin
                    r_bresp <= (r_err || w_err_beat) ? 2'b10 : 2'b00;
                end else begin
                    r_addr <= w_next_addr;
                    r_beat <= r_beat + 4'd1;
                end
            end else if (w_b_hs) begin
                r_prio_rd <= ~r_prio_rd;
            end
        end
    end

    // RAM array carries no reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (w_w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    r_mem[r_addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign arready     = w_arready;
    assign awready     = w_awready;
    assign wready      = w_wready;
    assign rvalid      = (r_state == S_RD);
    assign bvalid      = (r_state == S_WRESP);
    assign rdata       = r_rdata;
    assign rlast       = r_rlast;
    assign rid         = r_rid;
    assign rresp       = 2'b00;
    assign bid         = r_bid;
    assign bresp       = r_bresp;
    assign o_dbg_state = r_state;

endmodule
